// File: rtl/nbody_mem_responder_if.sv
// ============================================================================
// Module : nbody_mem_responder_if
// Brief  : Host and engine access bundle for the N-body memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface nbody_mem_responder_if;
    logic        host_wr_en;
    logic        host_rd_en;
    logic [31:0] host_addr;
    logic [79:0] host_wdata;
    logic        host_ready;
    logic [79:0] host_rdata;
    logic        host_rvalid;
    logic        host_err;
    logic        eng_req;
    logic        eng_we;
    logic [31:0] eng_addr;
    logic [79:0] eng_wdata;
    logic        eng_gnt;
    logic [79:0] eng_rdata;
    logic        eng_rvalid;

    modport slave (
        input  host_wr_en, host_rd_en, host_addr, host_wdata,
        output host_ready, host_rdata, host_rvalid, host_err,
        input  eng_req, eng_we, eng_addr, eng_wdata,
        output eng_gnt, eng_rdata, eng_rvalid
    );

    modport master (
        output host_wr_en, host_rd_en, host_addr, host_wdata,
        input  host_ready, host_rdata, host_rvalid, host_err,
        output eng_req, eng_we, eng_addr, eng_wdata,
        input  eng_gnt, eng_rdata, eng_rvalid
    );
endinterface

`default_nettype wire

// File: rtl/nbody_mem_responder.sv
// ============================================================================
// Module : nbody_mem_responder
// Brief  : Body/force storage with engine-priority arbitration and 1-cycle reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nbody_mem_responder #(
    parameter int          N_BODIES       = 2,
    parameter logic [31:0] FORCE_BASE     = 32'h190,
    parameter int          MAX_ENG_STREAK = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    nbody_mem_responder_if.slave bus
);

    localparam int          c_IDX_W      = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;
    localparam int          c_STREAK_W   = $clog2(MAX_ENG_STREAK + 1);
    localparam logic [31:0] c_NB         = 32'(N_BODIES);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_ENG_STREAK);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ENG  = 2'd1,
        ARB_HOST = 2'd2
    } arb_t;

    logic [79:0]           body_q  [N_BODIES];
    logic [31:0]           force_q [N_BODIES];
    logic [c_STREAK_W-1:0] streak_q, streak_d;
    logic [79:0]           host_rdata_q, eng_rdata_q;
    logic                  host_rvalid_q, host_err_q, eng_rvalid_q;

    logic              w_host_req, w_host_turn;
    arb_t              w_arb;
    logic [31:0]       w_addr, w_foff;
    logic [79:0]       w_wdata, w_rd_data;
    logic              w_we, w_body_hit, w_force_hit, w_miss;
    logic [c_IDX_W-1:0] w_bidx, w_fidx;

    // Host is only let in ahead of a requesting engine once the streak limit is hit.
    assign w_host_req  = bus.host_wr_en | bus.host_rd_en;
    assign w_host_turn = w_host_req && (streak_q == c_STREAK_MAX);

    always_comb begin
        w_arb = ARB_IDLE;
        if (rst_n) begin
            if (bus.eng_req && !w_host_turn) begin
                w_arb = ARB_ENG;
            end else if (w_host_req) begin
                w_arb = ARB_HOST;
            end
        end
    end

    assign bus.eng_gnt    = (w_arb == ARB_ENG);
    assign bus.host_ready = (w_arb != ARB_ENG);

    always_comb begin
        streak_d = streak_q;
        if (!w_host_req || (w_arb == ARB_HOST)) begin
            streak_d = '0;
        end else if ((w_arb == ARB_ENG) && (streak_q != c_STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    assign w_addr  = (w_arb == ARB_ENG) ? bus.eng_addr  : bus.host_addr;
    assign w_wdata = (w_arb == ARB_ENG) ? bus.eng_wdata : bus.host_wdata;
    assign w_we    = (w_arb == ARB_ENG) ? bus.eng_we    : bus.host_wr_en;

    assign w_foff      = w_addr - FORCE_BASE;
    assign w_body_hit  = (w_addr < c_NB);
    assign w_force_hit = (w_addr >= FORCE_BASE) && (w_foff < c_NB);
    assign w_miss      = !w_body_hit && !w_force_hit;
    assign w_bidx      = w_addr[c_IDX_W-1:0];
    assign w_fidx      = w_foff[c_IDX_W-1:0];

    always_comb begin
        w_rd_data = '0;
        if (w_body_hit) begin
            w_rd_data = body_q[w_bidx];
        end else if (w_force_hit) begin
            w_rd_data = {48'd0, force_q[w_fidx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BODIES; i++) begin
                body_q[i]  <= '0;
                force_q[i] <= '0;
            end
            streak_q      <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            host_err_q    <= 1'b0;
            eng_rdata_q   <= '0;
            eng_rvalid_q  <= 1'b0;
        end else begin
            streak_q <= streak_d;
            if ((w_arb != ARB_IDLE) && w_we) begin
                if (w_body_hit) begin
                    body_q[w_bidx] <= w_wdata;
                end else if (w_force_hit) begin
                    force_q[w_fidx] <= w_wdata[31:0];
                end
            end
            // A simultaneous host write+read is carried out as the write only.
            host_rvalid_q <= (w_arb == ARB_HOST) && bus.host_rd_en && !bus.host_wr_en;
            host_err_q    <= (w_arb == ARB_HOST) && (w_miss || (bus.host_rd_en && bus.host_wr_en));
            if ((w_arb == ARB_HOST) && bus.host_rd_en && !bus.host_wr_en) begin
                host_rdata_q <= w_rd_data;
            end
            eng_rvalid_q <= (w_arb == ARB_ENG) && !bus.eng_we;
            if ((w_arb == ARB_ENG) && !bus.eng_we) begin
                eng_rdata_q <= w_rd_data;
            end
        end
    end

    assign bus.host_rdata  = host_rdata_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_err    = host_err_q;
    assign bus.eng_rdata   = eng_rdata_q;
    assign bus.eng_rvalid  = eng_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_nbody_mem_responder.sv
// ============================================================================
// Module : tb_nbody_mem_responder
// Brief  : Directed scoreboard bench for the N-body memory responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nbody_mem_responder;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [79:0] d;
    } exp_t;

    localparam logic [79:0] c_B0  = 80'h0064006400C800C80005;
    localparam logic [79:0] c_B1  = 80'h00C800C8006400640002;
    localparam logic [79:0] c_NEW = 80'h0000000000000000ABCD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t hq[$];
    exp_t eq[$];

    nbody_mem_responder_if bus();

    nbody_mem_responder #(
        .N_BODIES      (2),
        .FORCE_BASE    (32'h190),
        .MAX_ENG_STREAK(4)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        chk("gnt_exclusive", 80'(bus.host_ready & bus.eng_gnt), 80'd0);
        if (bus.host_rvalid || bus.host_err) begin
            if (hq.size() == 0) begin
                chk("host_unexpected_resp", {78'd0, bus.host_rvalid, bus.host_err}, 80'd0);
            end else begin
                e = hq.pop_front();
                chk("host_rvalid", 80'(bus.host_rvalid), 80'(e.v));
                chk("host_err", 80'(bus.host_err), 80'(e.e));
                if (e.v) chk("host_rdata", bus.host_rdata, e.d);
            end
        end
        if (bus.eng_rvalid) begin
            if (eq.size() == 0) begin
                chk("eng_unexpected_resp", 80'(bus.eng_rvalid), 80'd0);
            end else begin
                e = eq.pop_front();
                chk("eng_rdata", bus.eng_rdata, e.d);
            end
        end
    end

    task automatic host_op(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [79:0] d, input logic ev, input logic ee,
                           input logic [79:0] ed);
        int waitc = 0;
        bus.host_wr_en = wr;
        bus.host_rd_en = rd;
        bus.host_addr  = a;
        bus.host_wdata = d;
        #1;
        while (!bus.host_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!bus.host_ready) chk("host_ready_timeout", 80'd0, 80'd1);
        else if (ev || ee) hq.push_back('{v: ev, e: ee, d: ed});
        @(posedge clk); #1;
        bus.host_wr_en = 1'b0;
        bus.host_rd_en = 1'b0;
    endtask

    task automatic eng_op(input logic we, input logic [31:0] a, input logic [79:0] d,
                          input logic [79:0] ed);
        int waitc = 0;
        bus.eng_req   = 1'b1;
        bus.eng_we    = we;
        bus.eng_addr  = a;
        bus.eng_wdata = d;
        #1;
        while (!bus.eng_gnt && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!bus.eng_gnt) chk("eng_gnt_timeout", 80'd0, 80'd1);
        else if (!we) eq.push_back('{v: 1'b1, e: 1'b0, d: ed});
        @(posedge clk); #1;
        bus.eng_req = 1'b0;
    endtask

    initial begin
        int cnt;
        bus.host_wr_en = 1'b0;
        bus.host_rd_en = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.eng_req    = 1'b0;
        bus.eng_we     = 1'b0;
        bus.eng_addr   = '0;
        bus.eng_wdata  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_host_ready", 80'(bus.host_ready), 80'd1);
        chk("rst_eng_gnt", 80'(bus.eng_gnt), 80'd0);
        chk("rst_host_rdata", bus.host_rdata, 80'd0);
        chk("rst_host_rvalid", 80'(bus.host_rvalid), 80'd0);
        chk("rst_host_err", 80'(bus.host_err), 80'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Body preload and readback; the read of body1 follows its write only one op later.
        host_op(1, 0, 32'd0, c_B0, 0, 0, '0);
        host_op(1, 0, 32'd1, c_B1, 0, 0, '0);
        host_op(0, 1, 32'd1, '0, 1, 0, c_B1);
        host_op(0, 1, 32'd0, '0, 1, 0, c_B0);

        // Force storage keeps only the low 32 bits.
        host_op(1, 0, 32'h190, 80'h00000000000300040000, 0, 0, '0);
        host_op(0, 1, 32'h190, '0, 1, 0, 80'h00000000000000040000);

        // Misses: read returns zero with err; bad write leaves arrays alone.
        host_op(0, 1, 32'h0C8, '0, 1, 1, 80'd0);
        host_op(1, 0, 32'h192, 80'hFFFFFFFFFFFFFFFFFFFF, 0, 1, '0);
        host_op(0, 1, 32'd0, '0, 1, 0, c_B0);
        host_op(0, 1, 32'h191, '0, 1, 0, 80'd0);

        // Write and read together: write happens, read is dropped, err pulses.
        host_op(1, 1, 32'd1, c_NEW, 0, 1, '0);
        host_op(0, 1, 32'd1, '0, 1, 0, c_NEW);

        // Engine side accesses.
        eng_op(0, 32'd0, '0, c_B0);
        eng_op(1, 32'h191, 80'hFFFFFFFFFFFFDEADBEEF, '0);
        host_op(0, 1, 32'h191, '0, 1, 0, 80'h000000000000DEADBEEF);
        eng_op(1, 32'h0C8, 80'h1234, '0);
        eng_op(0, 32'h0C8, '0, 80'd0);

        // Contention: engine hammers addr 1 while host waits to read addr 0.
        bus.eng_req    = 1'b1;
        bus.eng_we     = 1'b0;
        bus.eng_addr   = 32'd1;
        bus.host_rd_en = 1'b1;
        bus.host_addr  = 32'd0;
        cnt = 0;
        #1;
        for (int i = 0; i < 20 && !bus.host_ready; i++) begin
            if (bus.eng_gnt) begin
                cnt++;
                eq.push_back('{v: 1'b1, e: 1'b0, d: c_NEW});
            end
            @(posedge clk); #1;
        end
        chk("streak_eng_gnts", 80'(cnt), 80'd4);
        chk("streak_host_ready", 80'(bus.host_ready), 80'd1);
        chk("streak_eng_blocked", 80'(bus.eng_gnt), 80'd0);
        if (bus.host_ready) hq.push_back('{v: 1'b1, e: 1'b0, d: c_B0});
        @(posedge clk); #1;
        bus.host_rd_en = 1'b0;
        #1;
        chk("eng_resumes", 80'(bus.eng_gnt), 80'd1);
        if (bus.eng_gnt) eq.push_back('{v: 1'b1, e: 1'b0, d: c_NEW});
        @(posedge clk); #1;
        bus.eng_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset right after a read is accepted: its response must never appear.
        bus.host_rd_en = 1'b1;
        bus.host_addr  = 32'd0;
        #1;
        chk("inflight_ready", 80'(bus.host_ready), 80'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.host_rd_en = 1'b0;
        #1;
        chk("inrst_host_rvalid", 80'(bus.host_rvalid), 80'd0);
        chk("inrst_host_rdata", bus.host_rdata, 80'd0);
        chk("inrst_host_ready", 80'(bus.host_ready), 80'd1);
        chk("inrst_eng_rdata", bus.eng_rdata, 80'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        host_op(0, 1, 32'd0, '0, 1, 0, 80'd0);
        host_op(0, 1, 32'h190, '0, 1, 0, 80'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("host_queue_drained", 80'(hq.size()), 80'd0);
        chk("eng_queue_drained", 80'(eq.size()), 80'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
